// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage FSM encoding, payload defaults and
// the {pc_next, instr} payload record reused by the later pipeline registers.
package pipe_pkg;

    localparam int          PC_W_DEFAULT      = 32;
    localparam int          INSTR_W_DEFAULT   = 32;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // The encoding doubles as the entry count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0]    pc_next;
        logic [INSTR_W_DEFAULT-1:0] instr;
    } if_id_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: payload register plus valid bit, with a load
// control and a clear that returns the payload to its idle (NOP) value.
module pipe_slot #(
    parameter int           W       = 64,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         v
);

    logic [W-1:0] data_d, data_q;
    logic         v_d, v_q;

    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        if (clear) begin
            data_d = CLR_VAL;
            v_d    = 1'b0;
        end else if (load) begin
            data_d = d;
            v_d    = 1'b1;
        end
    end

    // NOTE: the payload is reset too, not just the valid bit, so the idle NOP
    // is driven downstream from the first reset and never an X.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= CLR_VAL;
            v_q    <= 1'b0;
        end else begin
            data_q <= data_d;
            v_q    <= v_d;
        end
    end

    assign q = data_q;
    assign v = v_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with a two-entry skid buffer, valid/ready on both
// sides, a global stall (enable) and a flush that leaves a NOP bubble.
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEFAULT,
    parameter int                 INSTR_W   = INSTR_W_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc_next,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc_next,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
);

    localparam int           W       = PC_W + INSTR_W;
    localparam logic [W-1:0] IDLE_WD = {{PC_W{1'b0}}, NOP_INSTR};

    stage_state_e state_d, state_q;
    logic [W-1:0] main_q, skid_q, main_in;
    logic         main_v, skid_v;
    logic         main_load, main_clear, main_from_skid;
    logic         skid_load, skid_clear;
    logic         in_fire, out_fire;

    assign in_ready = enable & ~skid_v;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_v & out_ready & enable;
    assign main_in  = main_from_skid ? skid_q : {in_pc_next, in_instr};

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        // Flush beats the stall: the bubble is inserted even while frozen.
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (enable) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    pipe_slot #(.W(W), .CLR_VAL(IDLE_WD)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_in),
        .q     (main_q),
        .v     (main_v)
    );

    pipe_slot #(.W(W), .CLR_VAL(IDLE_WD)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     ({in_pc_next, in_instr}),
        .q     (skid_q),
        .v     (skid_v)
    );

    assign out_valid   = main_v;
    assign out_pc_next = main_q[W-1:INSTR_W];
    assign out_instr   = main_q[INSTR_W-1:0];
    assign occupancy   = state_q;

endmodule
